// File: rtl/vx_mem_bus_responder_if.sv
// Request/response bus between a mem-bus requester (master) and an SRAM responder (slave).
interface vx_mem_bus_responder_if #(
    parameter int DATA_SIZE      = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 8,
    parameter int RSP_QUEUE_SIZE = 4
);
    localparam int PW = $clog2(RSP_QUEUE_SIZE + 1);

    logic                   req_valid;
    logic                   req_rw;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_SIZE-1:0]   req_byteen;
    logic [DATA_SIZE*8-1:0] req_data;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   req_ready;
    logic                   rsp_valid;
    logic [DATA_SIZE*8-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic                   rsp_ready;
    logic [PW-1:0]          pending;

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, pending
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, pending
    );
endinterface

// File: rtl/vx_mem_bus_responder.sv
// SRAM-backed mem-bus responder: tagged reads return in order after LATENCY cycles.
// Optional MEM_RSP_WRITE_ACK_EN: writes also return a zero-data acknowledge response.
module vx_mem_bus_responder #(
    parameter int DATA_SIZE      = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    vx_mem_bus_responder_if.slave        bus
);
    localparam int DW  = DATA_SIZE * 8;
    localparam int PW  = $clog2(RSP_QUEUE_SIZE + 1);
    localparam int QAW = $clog2(RSP_QUEUE_SIZE);
    localparam logic [PW-1:0]  QS_P     = PW'(RSP_QUEUE_SIZE);
    localparam logic [PW-1:0]  CNT_ONE  = PW'(1);
    localparam logic [QAW-1:0] PTR_ONE  = QAW'(1);

    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0]        old_word,
        input logic [DW-1:0]        new_word,
        input logic [DATA_SIZE-1:0] byteen
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int i = 0; i < DATA_SIZE; i++) begin
            if (byteen[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [DW-1:0]        mem_r [2**ADDR_WIDTH];
    logic [PW-1:0]        pending_r;
    logic [PW-1:0]        q_count_r;
    logic [QAW-1:0]       wr_ptr_r;
    logic [QAW-1:0]       rd_ptr_r;
    logic [DW-1:0]        q_data_r [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] q_tag_r  [RSP_QUEUE_SIZE];

    logic                 req_fire_s;
    logic                 wr_fire_s;
    logic                 rsp_gen_s;
    logic                 rsp_fire_s;
    logic [DW-1:0]        rd_word_s;
    logic                 push_valid_s;
    logic [DW-1:0]        push_data_s;
    logic [TAG_WIDTH-1:0] push_tag_s;

    // Admission depends only on the registered credit count, never on rsp_ready.
    assign bus.req_ready = !reset && (pending_r < QS_P);
    assign req_fire_s    = bus.req_valid && bus.req_ready;
    assign wr_fire_s     = req_fire_s && bus.req_rw;
    assign rsp_fire_s    = bus.rsp_valid && bus.rsp_ready;
`ifdef MEM_RSP_WRITE_ACK_EN
    assign rsp_gen_s     = req_fire_s;
`else
    assign rsp_gen_s     = req_fire_s && !bus.req_rw;
`endif
    assign rd_word_s     = bus.req_rw ? {DW{1'b0}} : mem_r[bus.req_addr];

    // Word array with byte-enable writes; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[bus.req_addr] <= merge_bytes(mem_r[bus.req_addr], bus.req_data, bus.req_byteen);
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid_s = rsp_gen_s;
            assign push_data_s  = rd_word_s;
            assign push_tag_s   = bus.req_tag;
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;
            logic [NSTG-1:0]      stg_valid_r;
            logic [DW-1:0]        stg_data_r [NSTG];
            logic [TAG_WIDTH-1:0] stg_tag_r  [NSTG];

            // Fixed-latency delay line between array sample and response queue.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stg_valid_r <= {NSTG{1'b0}};
                    for (int i = 0; i < NSTG; i++) begin
                        stg_data_r[i] <= {DW{1'b0}};
                        stg_tag_r[i]  <= {TAG_WIDTH{1'b0}};
                    end
                end else begin
                    stg_valid_r[0] <= rsp_gen_s;
                    stg_data_r[0]  <= rd_word_s;
                    stg_tag_r[0]   <= bus.req_tag;
                    for (int i = 1; i < NSTG; i++) begin
                        stg_valid_r[i] <= stg_valid_r[i-1];
                        stg_data_r[i]  <= stg_data_r[i-1];
                        stg_tag_r[i]   <= stg_tag_r[i-1];
                    end
                end
            end

            assign push_valid_s = stg_valid_r[NSTG-1];
            assign push_data_s  = stg_data_r[NSTG-1];
            assign push_tag_s   = stg_tag_r[NSTG-1];
        end
    endgenerate

    // Response queue storage; credits guarantee a free slot on every push.
    always_ff @(posedge clk) begin
        if (push_valid_s) begin
            q_data_r[wr_ptr_r] <= push_data_s;
            q_tag_r[wr_ptr_r]  <= push_tag_s;
        end
    end

    // Queue pointers, occupancy and outstanding-response credit count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {QAW{1'b0}};
            rd_ptr_r  <= {QAW{1'b0}};
            q_count_r <= {PW{1'b0}};
            pending_r <= {PW{1'b0}};
        end else begin
            if (push_valid_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rsp_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_valid_s, rsp_fire_s})
                2'b10:   q_count_r <= q_count_r + CNT_ONE;
                2'b01:   q_count_r <= q_count_r - CNT_ONE;
                default: q_count_r <= q_count_r;
            endcase
            case ({rsp_gen_s, rsp_fire_s})
                2'b10:   pending_r <= pending_r + CNT_ONE;
                2'b01:   pending_r <= pending_r - CNT_ONE;
                default: pending_r <= pending_r;
            endcase
        end
    end

    assign bus.rsp_valid = (q_count_r != {PW{1'b0}});
    assign bus.rsp_data  = bus.rsp_valid ? q_data_r[rd_ptr_r] : {DW{1'b0}};
    assign bus.rsp_tag   = bus.rsp_valid ? q_tag_r[rd_ptr_r]  : {TAG_WIDTH{1'b0}};
    assign bus.pending   = pending_r;

    vx_mem_bus_responder_chk #(
        .RSP_QUEUE_SIZE (RSP_QUEUE_SIZE)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .pending    (pending_r),
        .q_count    (q_count_r),
        .push_valid (push_valid_s)
    );
endmodule

// Simulation checks on credit accounting and queue occupancy.
module vx_mem_bus_responder_chk #(
    parameter int RSP_QUEUE_SIZE = 4
) (
    input logic                                 clk,
    input logic                                 reset,
    input logic [$clog2(RSP_QUEUE_SIZE+1)-1:0]  pending,
    input logic [$clog2(RSP_QUEUE_SIZE+1)-1:0]  q_count,
    input logic                                 push_valid
);
    localparam int PW = $clog2(RSP_QUEUE_SIZE + 1);
    localparam logic [PW-1:0] QS_P = PW'(RSP_QUEUE_SIZE);

    a_pending_bound: assert property (@(posedge clk) disable iff (reset) pending <= QS_P);
    a_no_full_push:  assert property (@(posedge clk) disable iff (reset) !(push_valid && (q_count == QS_P)));
endmodule

// File: tb/tb_vx_mem_bus_responder.sv
// Randomized bench for vx_mem_bus_responder against a queue-based reference model.
module tb_vx_mem_bus_responder;
    localparam int LAT = 2;
    localparam int QS  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vx_mem_bus_responder_if #(.DATA_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8), .RSP_QUEUE_SIZE(QS)) bus ();

    vx_mem_bus_responder #(
        .DATA_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] exp_data [$];
    logic [7:0]  exp_tag  [$];
    int          tag_log  [$];
    int          rsp_cycles [$];
    int          cyc = 0;
    int          fire_cyc = 0;
    int          first_valid_cyc = -1000;
    bit          arm_valid = 1'b0;
    int          n_stale = 0;
    logic [31:0] last_data;
    logic [7:0]  last_tag;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, observe, update the model, advance to next negedge.
    task automatic cycle(input bit v, input bit rw, input logic [9:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic [7:0] t, input bit rr, output bit acc);
        bit rq_fire;
        bit rs_fire;
        logic [31:0] ed;
        logic [7:0]  et;
        bus.req_valid  = v;
        bus.req_rw     = rw;
        bus.req_addr   = a;
        bus.req_byteen = be;
        bus.req_data   = d;
        bus.req_tag    = t;
        bus.rsp_ready  = rr;
        #1;
        cyc++;
        chk_eq("pending", bus.pending, exp_data.size());
        chk_eq("req_ready", bus.req_ready, (!rst && exp_data.size() < QS));
        rq_fire = v && bus.req_ready;
        rs_fire = bus.rsp_valid && rr;
        if (arm_valid && bus.rsp_valid) begin
            first_valid_cyc = cyc;
            arm_valid = 1'b0;
        end
        if (bus.rsp_valid && exp_data.size() == 0) begin
            n_stale++;
            chk_eq("rsp_spurious", bus.rsp_valid, 1'b0);
        end else if (rs_fire) begin
            ed = exp_data.pop_front();
            et = exp_tag.pop_front();
            chk_eq("rsp_data", bus.rsp_data, ed);
            chk_eq("rsp_tag", bus.rsp_tag, et);
            last_data = bus.rsp_data;
            last_tag  = bus.rsp_tag;
            tag_log.push_back(int'(bus.rsp_tag));
            rsp_cycles.push_back(cyc);
        end
        if (rq_fire) begin
            fire_cyc = cyc;
            if (rw) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
                end
`ifdef MEM_RSP_WRITE_ACK_EN
                exp_data.push_back(32'h0);
                exp_tag.push_back(t);
`endif
            end else begin
                exp_data.push_back(ref_mem[a]);
                exp_tag.push_back(t);
            end
        end
        acc = rq_fire;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input bit rw, input logic [9:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [7:0] t);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, rw, a, be, d, t, 1'b1, acc);
        if (!acc) chk_eq("req_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h0, rr, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 60 && exp_data.size() != 0; k++)
            cycle(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h0, 1'b1, acc);
        if (exp_data.size() != 0) chk_eq("drain_timeout", exp_data.size(), 0);
        idle(1, 1'b1);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int bad;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_byteen = '0;
        bus.req_data = '0; bus.req_tag = '0; bus.rsp_ready = 1'b0;
        @(negedge clk);

        // Reset held three cycles, then released
        for (int k = 0; k < 3; k++) begin
            idle(1, 1'b0);
            chk_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk_eq("ready_after_rst", bus.req_ready, 1'b1);

        // Initialise the working address range
        for (int a = 0; a < 64; a++) req(1'b1, 10'(a), 4'hF, $urandom, 8'(a));
        drain();

        // Full write then immediate read: latency, data, tag
        req(1'b1, 10'h010, 4'b1111, 32'hDEADBEEF, 8'h00);
        req(1'b0, 10'h010, 4'h0, 32'h0, 8'h5A);
        arm_valid = 1'b1;
        drain();
        chk_eq("t2_latency", first_valid_cyc - fire_cyc, LAT);
        chk_eq("t2_data", last_data, 32'hDEADBEEF);
        chk_eq("t2_tag", last_tag, 8'h5A);

        // Partial byte-enable write
        req(1'b1, 10'h010, 4'b0001, 32'h000000AA, 8'h01);
        req(1'b0, 10'h010, 4'h0, 32'h0, 8'h11);
        drain();
        chk_eq("t3_data", last_data, 32'hDEADBEAA);

        // Backpressure: six reads offered with rsp_ready low
        n_acc = 0;
        for (int t = 1; t <= 6; t++) begin
            cycle(1'b1, 1'b0, 10'h010, 4'h0, 32'h0, 8'(t), 1'b0, acc);
            n_acc += int'(acc);
        end
        idle(3, 1'b0);
        chk_eq("t4_accepted", n_acc, 4);
        chk_eq("t4_pending", bus.pending, 4);
        chk_eq("t4_req_ready", bus.req_ready, 1'b0);
        chk_eq("t4_head_tag", bus.rsp_tag, 8'h01);
        tag_log.delete();
        cycle(1'b1, 1'b0, 10'h010, 4'h0, 32'h0, 8'h05, 1'b1, acc);
        chk_eq("t4_no_ready_bypass", acc, 1'b0);
        req(1'b0, 10'h010, 4'h0, 32'h0, 8'h05);
        req(1'b0, 10'h010, 4'h0, 32'h0, 8'h06);
        drain();
        chk_eq("t4_rsp_count", tag_log.size(), 6);
        bad = 0;
        foreach (tag_log[i]) if (tag_log[i] != i + 1) bad++;
        chk_eq("t4_order", bad, 0);
        chk_eq("t4_pending_end", bus.pending, 0);

        // Streaming 64 back-to-back reads
        tag_log.delete();
        rsp_cycles.delete();
        n_acc = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 1'b0, 10'($urandom_range(32, 63)), 4'h0, 32'h0, 8'(i), 1'b1, acc);
            n_acc += int'(acc);
        end
        drain();
        chk_eq("t5_accepted", n_acc, 64);
        chk_eq("t5_rsp_count", rsp_cycles.size(), 64);
        if (rsp_cycles.size() == 64) chk_eq("t5_throughput", rsp_cycles[63] - rsp_cycles[0], 63);
        bad = 0;
        foreach (tag_log[i]) if (tag_log[i] != i) bad++;
        chk_eq("t5_order", bad, 0);

        // Randomized mixed traffic with random response stalls
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, 10'($urandom_range(32, 63)),
                  4'($urandom), $urandom, 8'($urandom), ($urandom % 4) != 0, acc);
        end
        drain();

        // Reset with three reads in flight
        for (int t = 0; t < 3; t++) cycle(1'b1, 1'b0, 10'h020, 4'h0, 32'h0, 8'(t + 8'h40), 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("t6_rsp_valid_rst", bus.rsp_valid, 1'b0);
        chk_eq("t6_pending_rst", bus.pending, 0);
        chk_eq("t6_ready_rst", bus.req_ready, 1'b0);
        exp_data.delete();
        exp_tag.delete();
        @(negedge clk);
        idle(2, 1'b1);
        rst = 1'b0;
        n_stale = 0;
        idle(8, 1'b1);
        chk_eq("t6_no_stale", n_stale, 0);
        req(1'b0, 10'h010, 4'h0, 32'h0, 8'h77);
        drain();
        chk_eq("t6_mem_kept", last_data, 32'hDEADBEAA);
        chk_eq("t6_mem_tag", last_tag, 8'h77);
`ifdef MEM_RSP_WRITE_ACK_EN
        req(1'b1, 10'h020, 4'hF, 32'h12345678, 8'h33);
        drain();
        chk_eq("t6_ack_tag", last_tag, 8'h33);
        chk_eq("t6_ack_data", last_data, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
